// File: rtl/buffer_16x4_drain_if.sv
// Handshake and bus bundle between the drain buffer and its surroundings.
// master drives start/rows/wr_ready; slave (the buffer) drives everything else.
interface buffer_16x4_drain_if #(
  parameter int ADDR_W = 9
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              row_valid;
  logic              row_ready;
  logic [127:0]      row_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [31:0]       wr_data;
  logic [ADDR_W-1:0] wr_addr;
  logic              busy;
  logic              done;

  modport master (
    output start, base_addr, row_valid, row_data, wr_ready,
    input  row_ready, wr_valid, wr_data, wr_addr, busy, done
  );

  modport slave (
    input  start, base_addr, row_valid, row_data, wr_ready,
    output row_ready, wr_valid, wr_data, wr_addr, busy, done
  );
endinterface

// File: rtl/buffer_16x4_drain.sv
// Row store that fills with ROWS 128-bit rows, then drains byte-swapped 32-bit words under valid/ready;
// first word one cycle after the last row, wr_* hold while stalled. DRAIN_COLMAJOR_EN selects column-major order.
module buffer_16x4_drain #(
  parameter int ROWS   = 4,
  parameter int ADDR_W = 9
) (
  input  logic                clk,
  input  logic                rst,
  buffer_16x4_drain_if.slave  bus
);
  localparam int NWORDS = ROWS * 4;
  localparam int RCW    = $clog2(ROWS);
  localparam int WCW    = $clog2(NWORDS);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [RCW-1:0]    row_cnt_q, row_cnt_d;
  logic [WCW-1:0]    word_cnt_q, word_cnt_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              done_q, done_d;
  logic [127:0]      row_q [ROWS];
  logic [127:0]      row_d [ROWS];

  logic           row_hs, wr_hs, last_row, last_word;
  logic [WCW-1:0] sel_idx;
  logic [RCW-1:0] sel_r;
  logic [1:0]     sel_k;
  logic [127:0]   sel_row;
  logic [31:0]    sel_w;
  logic [31:0]    sel_swapped;

  assign row_hs    = (state_q == FILL) && bus.row_valid;
  assign wr_hs     = (state_q == DRAIN) && bus.wr_ready;
  assign last_row  = (row_cnt_q == RCW'(ROWS - 1));
  assign last_word = (word_cnt_q == WCW'(NWORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = FILL;
      FILL:    if (row_hs && last_row) state_d = DRAIN;
      DRAIN:   if (wr_hs && last_word) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.row_ready = (state_q == FILL);
    bus.wr_valid  = (state_q == DRAIN);
    bus.busy      = (state_q != IDLE);
    bus.done      = done_q;
    bus.wr_data   = wr_data_q;
    bus.wr_addr   = wr_addr_q;
  end

  // Word presented next: index 0 on entry to DRAIN, word_cnt+1 after each handshake.
  always_comb begin
    sel_idx = '0;
    if (state_q == DRAIN) sel_idx = word_cnt_q + WCW'(1);
`ifdef DRAIN_COLMAJOR_EN
    sel_k = 2'(sel_idx / WCW'(ROWS));
    sel_r = RCW'(sel_idx % WCW'(ROWS));
`else
    sel_r = sel_idx[WCW-1:2];
    sel_k = sel_idx[1:0];
`endif
    sel_row = row_q[sel_r];
    case (sel_k)
      2'd0:    sel_w = sel_row[31:0];
      2'd1:    sel_w = sel_row[63:32];
      2'd2:    sel_w = sel_row[95:64];
      default: sel_w = sel_row[127:96];
    endcase
    sel_swapped = {sel_w[7:0], sel_w[15:8], sel_w[23:16], sel_w[31:24]};
  end

  always_comb begin
    base_d     = base_q;
    row_cnt_d  = row_cnt_q;
    word_cnt_d = word_cnt_q;
    wr_data_d  = wr_data_q;
    wr_addr_d  = wr_addr_q;
    done_d     = 1'b0;
    row_d      = row_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          base_d     = bus.base_addr;
          row_cnt_d  = '0;
          word_cnt_d = '0;
        end
      end
      FILL: begin
        if (row_hs) begin
          row_d[row_cnt_q] = bus.row_data;
          row_cnt_d        = row_cnt_q + RCW'(1);
          if (last_row) begin
            wr_data_d  = sel_swapped;
            wr_addr_d  = base_q;
            word_cnt_d = '0;
          end
        end
      end
      DRAIN: begin
        if (wr_hs) begin
          if (last_word) begin
            done_d = 1'b1;
          end else begin
            word_cnt_d = sel_idx;
            wr_data_d  = sel_swapped;
            wr_addr_d  = base_q + ADDR_W'(sel_idx);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q     <= '0;
      row_cnt_q  <= '0;
      word_cnt_q <= '0;
      wr_data_q  <= '0;
      wr_addr_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      base_q     <= base_d;
      row_cnt_q  <= row_cnt_d;
      word_cnt_q <= word_cnt_d;
      wr_data_q  <= wr_data_d;
      wr_addr_q  <= wr_addr_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    row_q <= row_d;
  end
endmodule

// File: tb/tb_buffer_16x4_drain.sv
// Scoreboard bench for buffer_16x4_drain: directed blocks push expected words, a negedge monitor pops and compares.
module tb_buffer_16x4_drain;
  localparam int ROWS   = 4;
  localparam int ADDR_W = 9;
  localparam int NW     = ROWS * 4;

  typedef struct packed {
    logic [31:0]       d;
    logic [ADDR_W-1:0] a;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  buffer_16x4_drain_if #(.ADDR_W(ADDR_W)) bus ();
  buffer_16x4_drain #(.ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q [$];
  int   hs_cnt   = 0;
  int   done_cnt = 0;
  bit   done_exp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: done must follow the handshake that empties the queue; every presented word must be the queue head.
  always @(negedge clk) begin
    if (bus.done || done_exp) check("done_pulse", 32'(bus.done), 32'(done_exp));
    if (bus.done) done_cnt++;
    done_exp = 1'b0;
    if (rst) begin
      exp_q.delete();
    end else if (bus.wr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'(bus.wr_data), 32'hFFFF_FFFF);
      end else begin
        check("wr_data", bus.wr_data, exp_q[0].d);
        check("wr_addr", 32'(bus.wr_addr), 32'(exp_q[0].a));
        if (bus.wr_ready) begin
          if (exp_q.size() == 1) done_exp = 1'b1;
          void'(exp_q.pop_front());
          hs_cnt++;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mkrow(input int r, input int seed);
    logic [127:0] v;
    for (int n = 0; n < 16; n++) v[8*n +: 8] = 8'(16*r + n + seed);
    return v;
  endfunction

  task automatic push_block(input logic [ADDR_W-1:0] base, input int seed);
    exp_t e;
    int   r, k, b0;
    for (int j = 0; j < NW; j++) begin
`ifdef DRAIN_COLMAJOR_EN
      k = j / ROWS;
      r = j % ROWS;
`else
      r = j / 4;
      k = j % 4;
`endif
      b0  = 16*r + 4*k + seed;
      e.d = {8'(b0), 8'(b0 + 1), 8'(b0 + 2), 8'(b0 + 3)};
      e.a = ADDR_W'(int'(base) + j);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_block(input logic [ADDR_W-1:0] base, input int seed);
    bus.start     = 1'b1;
    bus.base_addr = base;
    push_block(base, seed);
    tick;
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  task automatic send_rows(input int seed, input int gap, input bit extra_start);
    for (int r = 0; r < ROWS; r++) begin
      for (int g = 0; g < gap; g++) begin
        if (extra_start && r == 2 && g == 0) begin
          bus.start     = 1'b1;
          bus.base_addr = 9'h0AA;
        end
        tick;
        bus.start = 1'b0;
      end
      if (r == ROWS - 1) begin
        check("pre_drain_valid", 32'(bus.wr_valid), 32'd0);
        check("fill_row_ready", 32'(bus.row_ready), 32'd1);
      end
      bus.row_valid = 1'b1;
      bus.row_data  = mkrow(r, seed);
      tick;
      bus.row_valid = 1'b0;
    end
    check("drain_latency", 32'(bus.wr_valid), 32'd1);
    check("drain_row_ready", 32'(bus.row_ready), 32'd0);
  endtask

  task automatic drain(input bit bp, input bit junk, input bit chain,
                       input logic [ADDR_W-1:0] nbase, input int nseed);
    int h0, d0, hit, c;
    h0  = hs_cnt;
    d0  = done_cnt;
    hit = -1;
    for (c = 1; c <= 300; c++) begin
      bus.wr_ready  = bp ? ((c - 1) % 4 == 0 || (c - 1) % 4 == 3) : 1'b1;
      bus.row_valid = junk;
      bus.row_data  = {4{32'hDEAD_BEEF}};
      tick;
      if (hit < 0 && hs_cnt - h0 == NW) hit = c;
      if (chain && hit == c) begin
        bus.row_valid = 1'b0;
        start_block(nbase, nseed);
        check("done_with_chain", 32'(done_cnt - d0), 32'd1);
        break;
      end
      if (done_cnt != d0) break;
    end
    bus.row_valid = 1'b0;
    bus.wr_ready  = 1'b1;
    check("handshake_count", 32'(hs_cnt - h0), 32'(NW));
    if (!chain) check("done_count", 32'(done_cnt - d0), 32'd1);
    if (!bp) check("drain_cycles", 32'(hit), 32'(NW));
  endtask

  initial begin
    int h0, d0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.row_valid = 1'b0;
    bus.row_data  = '0;
    bus.wr_ready  = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    check("rst_row_ready", 32'(bus.row_ready), 32'd0);
    check("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_wr_data", bus.wr_data, 32'd0);
    check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);

    // Basic drain, then backpressure with stray row_valid and a start in the done cycle into the wrap block.
    start_block(9'h010, 0);
    send_rows(0, 0, 1'b0);
    drain(1'b0, 1'b0, 1'b0, '0, 0);

    start_block(9'h040, 8'h40);
    send_rows(8'h40, 0, 1'b0);
    drain(1'b1, 1'b1, 1'b1, 9'h1FC, 8'h20);

    send_rows(8'h20, 0, 1'b0);
    drain(1'b0, 1'b0, 1'b0, '0, 0);

    start_block(9'h080, 8'h11);
    send_rows(8'h11, 3, 1'b1);
    drain(1'b0, 1'b0, 1'b0, '0, 0);

    // Abort after the fifth accepted word.
    start_block(9'h100, 8'h60);
    send_rows(8'h60, 0, 1'b0);
    h0 = hs_cnt;
    for (int c = 0; c < 50 && hs_cnt - h0 < 5; c++) tick;
    check("words_before_abort", 32'(hs_cnt - h0), 32'd5);
    rst          = 1'b1;
    bus.wr_ready = 1'b0;
    tick;
    rst          = 1'b0;
    bus.wr_ready = 1'b1;
    d0 = done_cnt;
    check("abort_wr_valid", 32'(bus.wr_valid), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_wr_data", bus.wr_data, 32'd0);
    repeat (3) tick;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);

    start_block(9'h120, 8'h80);
    send_rows(8'h80, 0, 1'b0);
    drain(1'b0, 1'b0, 1'b0, '0, 0);

    repeat (2) tick;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_busy", 32'(bus.busy), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
